load_sequencer: RTL

Multicycle load controller between the RV32I core's memory stage and the data memory port. Accepts one load (LB/LH/LW/LBU/LHU) at a time, issues one or two word-aligned memory reads with a ready handshake, extracts the addressed byte/halfword/word and sign- or zero-extends it to XLEN. Result and fault status go back to the core's register-writeback sequencing.

---
 rtl/load_sequencer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/load_sequencer.sv
//-----------------------------------------------------------------------------
// load_sequencer
//
// Multicycle load controller sitting between the RV32I memory stage and the
// data memory read port. One load (LB/LH/LW/LBU/LHU) is accepted at a time.
// The controller issues one or two word-aligned reads with a ready handshake,
// extracts the addressed byte/halfword/word, and sign- or zero-extends it.
//
// Build option:
//   MISALIGNED_SPLIT_EN  defined   -> misaligned LH/LHU/LW are serviced; an
//                                     access that crosses a word boundary is
//                                     split into two reads (REQ0 then REQ1).
//                        undefined -> misaligned LH/LHU/LW fault immediately
//                                     without touching memory.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   load request, sampled in IDLE or DONE
//   addr       in   byte address of the load (captured with start)
//   funct3     in   RV32I load funct3 (captured with start)
//   busy       out  high while a memory read is outstanding (REQ0/REQ1)
//   done       out  single-cycle completion pulse
//   data_out   out  extended load result, held until the next completion
//   fault      out  illegal funct3 / unserviceable misalignment, held
//   mem_req    out  memory read request
//   mem_addr   out  word-aligned memory read address
//   mem_ready  in   read completes on an edge with mem_req && mem_ready
//   mem_rdata  in   read data, sampled on the completing edge
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module load_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] addr,
    input  logic [2:0]      funct3,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] data_out,
    output logic            fault,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ0 = 2'd1,
        REQ1 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_reg,    state_next;
    logic [XLEN-1:0]   addr_reg,     addr_next;
    logic [2:0]        funct3_reg,   funct3_next;
    logic [XLEN-1:0]   word0_reg,    word0_next;
    logic [XLEN-1:0]   data_out_reg, data_out_next;
    logic              fault_reg,    fault_next;

    //-------------------------------------------------------------------------
    // Request classification on the incoming (not yet captured) request.
    //-------------------------------------------------------------------------
    logic req_illegal;
    logic req_misaligned;
    logic req_fault;

    always_comb begin
        // 011 and 11x are not loads in RV32I.
        req_illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        req_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                         ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`ifdef MISALIGNED_SPLIT_EN
        req_fault      = req_illegal;
`else
        req_fault      = req_illegal || req_misaligned;
`endif
    end

    //-------------------------------------------------------------------------
    // Word-boundary crossing for the captured request. Without split support
    // a crossing access never reaches REQ0, so REQ1 is pruned away.
    //-------------------------------------------------------------------------
    logic crosses;

`ifdef MISALIGNED_SPLIT_EN
    always_comb begin
        crosses = ((funct3_reg[1:0] == 2'b01) && (addr_reg[1:0] == 2'b11)) ||
                  ((funct3_reg[1:0] == 2'b10) && (addr_reg[1:0] != 2'b00));
    end
`else
    always_comb begin
        crosses = 1'b0;
    end
`endif

    //-------------------------------------------------------------------------
    // Extraction datapath. The 64-bit window is {word1, word0}; on a single
    // read the upper word is zero and the lower word comes straight from the
    // memory bus, so the result is ready on the completing edge.
    //-------------------------------------------------------------------------
    logic [2*XLEN-1:0] window;
    logic [7:0]        win_bytes [8];
    logic [7:0]        sel_bytes [4];
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   load_result;
    logic              sign_ext;

    always_comb begin
        if (state_reg == REQ1) begin
            window = {mem_rdata, word0_reg};
        end else begin
            window = {{XLEN{1'b0}}, mem_rdata};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_win
            assign win_bytes[gi] = window[8*gi +: 8];
        end
        // Right shift by 8*offset expressed as a byte-lane mux; the offset
        // is at most 3, so lane gi+offset never leaves the 8-byte window.
        for (gi = 0; gi < 4; gi++) begin : g_sel
            assign sel_bytes[gi] = win_bytes[3'(addr_reg[1:0]) + 3'(gi)];
        end
    endgenerate

    assign raw = {sel_bytes[3], sel_bytes[2], sel_bytes[1], sel_bytes[0]};

    always_comb begin
        sign_ext = ~funct3_reg[2];
        case (funct3_reg[1:0])
            2'b00:   load_result = {{(XLEN-8){sign_ext & raw[7]}},   raw[7:0]};
            2'b01:   load_result = {{(XLEN-16){sign_ext & raw[15]}}, raw[15:0]};
            default: load_result = raw;
        endcase
    end

    //-------------------------------------------------------------------------
    // State register
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            funct3_reg   <= '0;
            word0_reg    <= '0;
            data_out_reg <= '0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            funct3_reg   <= funct3_next;
            word0_reg    <= word0_next;
            data_out_reg <= data_out_next;
            fault_reg    <= fault_next;
        end
    end

    //-------------------------------------------------------------------------
    // Next-state and output logic
    //-------------------------------------------------------------------------
    logic [XLEN-1:0] word_addr;

    assign word_addr = {addr_reg[XLEN-1:2], 2'b00};

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        funct3_next   = funct3_reg;
        word0_next    = word0_reg;
        data_out_next = data_out_reg;
        fault_next    = fault_reg;
        busy          = 1'b0;
        done          = 1'b0;
        mem_req       = 1'b0;
        mem_addr      = '0;

        case (state_reg)
            IDLE, DONE: begin
                done = (state_reg == DONE);
                if (start) begin
                    addr_next   = addr;
                    funct3_next = funct3;
                    if (req_fault) begin
                        state_next    = DONE;
                        data_out_next = '0;
                        fault_next    = 1'b1;
                    end else begin
                        state_next = REQ0;
                    end
                end else begin
                    state_next = IDLE;
                end
            end

            REQ0: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = word_addr;
                if (mem_ready) begin
                    word0_next = mem_rdata;
                    if (crosses) begin
                        state_next = REQ1;
                    end else begin
                        state_next    = DONE;
                        data_out_next = load_result;
                        fault_next    = 1'b0;
                    end
                end
            end

            REQ1: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                // XLEN-bit add wraps 0xFFFFFFFC to 0x00000000.
                mem_addr = word_addr + XLEN'(4);
                if (mem_ready) begin
                    state_next    = DONE;
                    data_out_next = load_result;
                    fault_next    = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign data_out = data_out_reg;
    assign fault    = fault_reg;

endmodule
